// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Round-robin arbiter that shares the single register-file write path
//   among NREQ requesters. The winner's data is registered onto wr_data and
//   a one-hot enable is registered onto wr_en, which feeds the en inputs of
//   the register bank. At most one register is written per cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active low
//   stall      in   1 = no new grant this cycle
//   req        in   per-requester level write request
//   req_addr   in   requester i address at [i*AW +: AW]
//   req_data   in   requester i data at [i*n +: n]
//   gnt        out  one-hot grant pulse (registered)
//   wr_en      out  one-hot register enables (registered)
//   wr_data    out  write data to all register D inputs (registered)
//   busy       out  1 while in WRITE
//   err        out  1-cycle pulse: granted address >= NREG
//   state_dbg  out  current FSM state (0 = IDLE, 1 = WRITE)
//   ptr_dbg    out  current round-robin pointer
//
// Handshake: a requester raises req with stable addr/data and holds them
// until it samples its gnt bit high; gnt is asserted for exactly one cycle
// per accepted request, and a req still high in the following cycle counts
// as a new request.
module regfile_write_arbiter #(
  parameter int WORD_LENGTH = 16,
  parameter int n           = WORD_LENGTH,
  parameter int NREQ        = 4,
  parameter int NREG        = 8,
  parameter int AW          = 3,
  localparam int PW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*n-1:0]  req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREG-1:0]    wr_en,
  output logic [n-1:0]       wr_data,
  output logic               busy,
  output logic               err,
  output logic               state_dbg,
  output logic [PW-1:0]      ptr_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREG-1:0] wr_en_q, wr_en_d;
  logic [n-1:0]    wr_data_q, wr_data_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] eligible;
  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   ptr_nxt;
  logic [AW-1:0]   win_addr;
  logic [n-1:0]    win_data;
  logic            addr_ok;

  // (p + k) mod NREQ without relying on NREQ being a power of two.
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Arbitration. Masking with the current gnt stops a requester that has
  // not yet observed its grant from being granted a second time.
  always_comb begin
    eligible = req & ~gnt_q & {NREQ{~stall}};
    found    = 1'b0;
    win      = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_idx(ptr_q, k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_addr = req_addr[int'(win)*AW +: AW];
    win_data = req_data[int'(win)*n +: n];
    addr_ok  = int'(win_addr) < NREG;
    ptr_nxt  = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
  end

  // Next-state and next-output values. With no winner the outputs drop
  // to zero while ptr and wr_data keep their values.
  always_comb begin
    state_d   = IDLE;
    gnt_d     = '0;
    wr_en_d   = '0;
    err_d     = 1'b0;
    ptr_d     = ptr_q;
    wr_data_d = wr_data_q;
    if (found) begin
      state_d   = WRITE;
      gnt_d     = NREQ'(1) << win;
      wr_data_d = win_data;
      ptr_d     = ptr_nxt;
      if (addr_ok) wr_en_d = NREG'(1) << win_addr;
      else         err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign gnt       = gnt_q;
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign err       = err_q;
  assign busy      = (state_q == WRITE);
  assign state_dbg = state_q;
  assign ptr_dbg   = ptr_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int n    = 16;
  localparam int NREQ = 4;
  localparam int NREG = 6;
  localparam int AW   = 3;
  localparam int PW   = 2;
  localparam int EW   = 2 + NREQ + NREG + n;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst_n;
  logic               stall;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*n-1:0]  req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREG-1:0]    wr_en;
  logic [n-1:0]       wr_data;
  logic               busy;
  logic               err;
  logic               state_dbg;
  logic [PW-1:0]      ptr_dbg;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .WORD_LENGTH(n), .NREQ(NREQ), .NREG(NREG), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .req(req),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
    .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .err(err),
    .state_dbg(state_dbg), .ptr_dbg(ptr_dbg)
  );

  // Register bank built from enable flops, driven only by the DUT outputs.
  logic [n-1:0] bank [NREG] = '{default: '0};
  always @(posedge clk) begin
    for (int r = 0; r < NREG; r++)
      if (wr_en[r]) bank[r] <= wr_data;
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [n-1:0]  exp_bank [NREG] = '{default: '0};
  logic [n-1:0]  held_data = '0;
  int            n_cmp  = 0;
  int            n_fail = 0;

  // Expected output word: {busy, err, gnt, wr_en, wr_data}.
  task automatic push_write(input logic [NREQ-1:0] g, input int addr, input logic [n-1:0] d);
    logic [NREG-1:0] wen;
    logic            e;
    wen = '0;
    e   = 1'b0;
    if (addr < NREG) wen[addr] = 1'b1;
    else             e = 1'b1;
    held_data = d;
    exp_q.push_back({1'b1, e, g, wen, d});
  endtask

  task automatic push_idle();
    exp_q.push_back({1'b0, 1'b0, {NREQ{1'b0}}, {NREG{1'b0}}, held_data});
  endtask

  task automatic tick(input string tag);
    logic [EW-1:0] o, e;
    @(posedge clk);
    #1;
    o = {busy, err, gnt, wr_en, wr_data};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: no expected entry, observed=%h", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_bank(input string tag);
    for (int r = 0; r < NREG; r++) begin
      n_cmp++;
      assert (bank[r] === exp_bank[r]) else begin
        n_fail++;
        $error("FAIL %s reg%0d: observed=%h expected=%h", tag, r, bank[r], exp_bank[r]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input int addr, input logic [n-1:0] d);
    req[i] = 1'b1;
    req_addr[i*AW +: AW] = AW'(addr);
    req_data[i*n +: n]   = d;
  endtask

  task automatic clr_req(input int i);
    req[i] = 1'b0;
    req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
    req_data[i*n +: n]   = n'($urandom_range(0, 65535));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    held_data = '0;
    push_idle();
    tick(tag);
    check_val({tag, "_ptr"}, int'(ptr_dbg), 0);
    check_val({tag, "_state"}, int'(state_dbg), 0);
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    stall    = 1'b0;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;

    // Reset values.
    do_reset("reset");
    check_bank("reset_bank");

    // Single request: grant and enable one cycle later, register at t+2.
    set_req(2, 5, 16'hA5A5);
    push_write(4'b0100, 5, 16'hA5A5);
    tick("t1_grant");
    clr_req(2);
    push_idle();
    tick("t1_idle");
    exp_bank[5] = 16'hA5A5;
    check_bank("t1_bank");
    check_val("t1_ptr", int'(ptr_dbg), 3);

    // All four requesters from ptr=0: grants 0,1,2,3 back to back.
    do_reset("t2_reset");
    for (int i = 0; i < NREQ; i++) set_req(i, i, n'(16'h1000 + i));
    for (int i = 0; i < NREQ; i++) begin
      push_write(NREQ'(1) << i, i, n'(16'h1000 + i));
      tick("t2_rr");
      clr_req(i);
    end
    push_idle();
    tick("t2_idle");
    for (int i = 0; i < NREQ; i++) exp_bank[i] = n'(16'h1000 + i);
    check_bank("t2_bank");
    check_val("t2_ptr_wrap", int'(ptr_dbg), 0);

    // Stall holds off a pending request; grant follows the stall release.
    stall = 1'b1;
    set_req(1, 4, 16'h3333);
    for (int c = 0; c < 3; c++) begin
      push_idle();
      tick("t3_stall");
    end
    stall = 1'b0;
    push_write(4'b0010, 4, 16'h3333);
    tick("t3_release");
    clr_req(1);
    push_idle();
    tick("t3_idle");
    exp_bank[4] = 16'h3333;
    check_bank("t3_bank");

    // Out-of-range address: grant, no enable, one-cycle err.
    set_req(3, 7, 16'hBEEF);
    push_write(4'b1000, 7, 16'hBEEF);
    tick("t4_err");
    clr_req(3);
    push_idle();
    tick("t4_idle");
    check_bank("t4_bank");

    // Request dropped before it could be granted: nothing happens.
    stall = 1'b1;
    set_req(2, 0, 16'hDEAD);
    push_idle();
    tick("t4b_stalled");
    clr_req(2);
    stall = 1'b0;
    push_idle();
    tick("t4b_dropped");
    check_bank("t4b_bank");

    // Reset during a WRITE: the pending second request is not written,
    // and is arbitrated again once reset is released.
    set_req(0, 1, 16'h1111);
    set_req(1, 2, 16'h2222);
    push_write(4'b0001, 1, 16'h1111);
    tick("t5_write");
    clr_req(0);
    exp_bank[1] = 16'h1111;
    do_reset("t5_reset");
    check_val("t5_reg2_kept", int'(bank[2]), int'(exp_bank[2]));
    push_write(4'b0010, 2, 16'h2222);
    tick("t5_after_reset");
    clr_req(1);
    push_idle();
    tick("t5_idle");
    exp_bank[2] = 16'h2222;
    check_bank("t5_bank");

    // Single requester holding req: granted every other cycle.
    set_req(0, 3, 16'h6666);
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0) push_write(4'b0001, 3, 16'h6666);
      else            push_idle();
      tick("t6_alt");
    end
    clr_req(0);
    push_idle();
    tick("t6_idle");
    exp_bank[3] = 16'h6666;
    check_bank("t6_bank");

    // Same address from two requesters: later grant's data remains.
    do_reset("t6b_reset");
    set_req(0, 5, 16'hAAAA);
    set_req(1, 5, 16'hBBBB);
    push_write(4'b0001, 5, 16'hAAAA);
    tick("t6b_first");
    clr_req(0);
    push_write(4'b0010, 5, 16'hBBBB);
    tick("t6b_second");
    clr_req(1);
    push_idle();
    tick("t6b_idle");
    exp_bank[5] = 16'hBBBB;
    check_bank("t6b_bank");

    check_val("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
